// File: rtl/unidec_pkg.sv
// Shared state encoding, word container and prefix helpers for the unique-decipherability checker.
// Words travel in a fixed-maximum struct (8 symbols x 8 bits) so the helpers serve any instance up to that size.
package unidec_pkg;

    localparam int PKG_MAX_LEN = 8;
    localparam int PKG_SYM_W   = 8;
    localparam int PKG_LEN_W   = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_START  = 2'd1;
    localparam state_t ST_SEARCH = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    typedef struct packed {
        logic [PKG_MAX_LEN-1:0][PKG_SYM_W-1:0] sym;
        logic [PKG_LEN_W-1:0]                  len;
    } word_t;

    // True when p is a (not necessarily proper) prefix of w; only the first len(p) symbols are compared.
    function automatic logic is_prefix(input word_t p, input word_t w);
        logic match;
        match = (p.len <= w.len);
        for (int i = 0; i < PKG_MAX_LEN; i++) begin
            if (i < int'(p.len) && p.sym[i] != w.sym[i]) match = 1'b0;
        end
        return match;
    endfunction

    // Removes n leading symbols; vacated high symbols are zero-filled.
    function automatic word_t drop_prefix(input word_t w, input logic [PKG_LEN_W-1:0] n);
        word_t r;
        r = '0;
        for (int i = 0; i < PKG_MAX_LEN; i++) begin
            for (int j = 0; j < PKG_MAX_LEN; j++) begin
                if (j == i + int'(n)) r.sym[i] = w.sym[j];
            end
        end
        r.len = w.len - n;
        return r;
    endfunction

endpackage

// File: rtl/unidec_codebook.sv
// Codebook register file: one write port, two combinational read ports, a valid bit per entry.
// An entry is valid only when it was written with a non-zero length.
module unidec_codebook #(
    parameter int SYM_W     = 3,
    parameter int MAX_LEN   = 5,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = $clog2(NUM_WORDS),
    parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [MAX_LEN*SYM_W-1:0] wr_sym,
    input  logic [LEN_W-1:0]         wr_len,
    input  logic [IDX_W-1:0]         rd_idx_a,
    output logic [MAX_LEN*SYM_W-1:0] rd_sym_a,
    output logic [LEN_W-1:0]         rd_len_a,
    output logic                     rd_valid_a,
    input  logic [IDX_W-1:0]         rd_idx_b,
    output logic [MAX_LEN*SYM_W-1:0] rd_sym_b,
    output logic [LEN_W-1:0]         rd_len_b,
    output logic                     rd_valid_b
);

    logic [MAX_LEN*SYM_W-1:0] sym_mem [NUM_WORDS];
    logic [LEN_W-1:0]         len_mem [NUM_WORDS];
    logic [NUM_WORDS-1:0]     valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                sym_mem[i] <= '0;
                len_mem[i] <= '0;
            end
            valid <= '0;
        end else if (wr_en) begin
            sym_mem[wr_idx] <= wr_sym;
            len_mem[wr_idx] <= wr_len;
            valid[wr_idx]   <= (wr_len != '0);
        end
    end

    assign rd_sym_a   = sym_mem[rd_idx_a];
    assign rd_len_a   = len_mem[rd_idx_a];
    assign rd_valid_a = valid[rd_idx_a];
    assign rd_sym_b   = sym_mem[rd_idx_b];
    assign rd_len_b   = len_mem[rd_idx_b];
    assign rd_valid_b = valid[rd_idx_b];

endmodule

// File: rtl/unidec_param_checker.sv
// Unique-decipherability checker: a Sardinas-Patterson dangling-suffix search steered by
// free selector inputs, one step per enabled clock, over a run-time loadable codebook.
module unidec_param_checker
    import unidec_pkg::*;
#(
    parameter int SYM_W     = 3,
    parameter int MAX_LEN   = 5,
    parameter int NUM_WORDS = 8,
    parameter int MAX_STEPS = 15,
    parameter int IDX_W     = $clog2(NUM_WORDS),
    parameter int LEN_W     = $clog2(MAX_LEN + 1),
    parameter int CNT_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [IDX_W-1:0]         load_idx,
    input  logic [MAX_LEN*SYM_W-1:0] load_sym,
    input  logic [LEN_W-1:0]         load_len,
    input  logic                     start,
    input  logic                     step_en,
    input  logic [IDX_W-1:0]         sel_word,
    input  logic [IDX_W-1:0]         sel_alt,
    output logic                     busy,
    output logic                     found,
    output logic                     trap,
    output logic                     exhausted,
    output logic [CNT_W-1:0]         step_cnt,
    output logic [LEN_W-1:0]         cur_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    word_t  suffix;

    logic                     wr_en;
    logic [MAX_LEN*SYM_W-1:0] sym_a, sym_b;
    logic [LEN_W-1:0]         len_a, len_b;
    logic                     valid_a, valid_b;

    assign wr_en = load_en && (state == ST_IDLE);

    unidec_codebook #(
        .SYM_W     (SYM_W),
        .MAX_LEN   (MAX_LEN),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W),
        .LEN_W     (LEN_W)
    ) u_codebook (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (load_idx),
        .wr_sym     (load_sym),
        .wr_len     (load_len),
        .rd_idx_a   (sel_word),
        .rd_sym_a   (sym_a),
        .rd_len_a   (len_a),
        .rd_valid_a (valid_a),
        .rd_idx_b   (sel_alt),
        .rd_sym_b   (sym_b),
        .rd_len_b   (len_b),
        .rd_valid_b (valid_b)
    );

    function automatic word_t to_word(input logic [MAX_LEN*SYM_W-1:0] s, input logic [LEN_W-1:0] l);
        word_t r;
        r = '0;
        for (int i = 0; i < MAX_LEN; i++) r.sym[i][SYM_W-1:0] = s[i*SYM_W +: SYM_W];
        r.len[LEN_W-1:0] = l;
        return r;
    endfunction

    word_t            word_a, word_b, adv_word;
    logic             a_pre_b, b_pre_a, a_pre_w, w_pre_a;
    logic             advance, trap_now, found_now;
    logic [CNT_W-1:0] cnt_inc;

    assign word_a  = to_word(sym_a, len_a);
    assign word_b  = to_word(sym_b, len_b);
    assign a_pre_b = is_prefix(word_a, word_b);
    assign b_pre_a = is_prefix(word_b, word_a);
    assign a_pre_w = is_prefix(word_a, suffix);
    assign w_pre_a = is_prefix(suffix, word_a);
    assign cnt_inc = step_cnt + CNT_ONE;

    always_comb begin
        advance   = 1'b0;
        trap_now  = 1'b0;
        found_now = 1'b0;
        adv_word  = suffix;
        case (state)
            ST_START: if (step_en) begin
                if (sel_word == sel_alt || !valid_a || !valid_b) begin
                    trap_now = 1'b1;
                end else if (a_pre_b && word_a.len < word_b.len) begin
                    advance  = 1'b1;
                    adv_word = drop_prefix(word_b, word_a.len);
                end else if (b_pre_a && word_b.len < word_a.len) begin
                    advance  = 1'b1;
                    adv_word = drop_prefix(word_a, word_b.len);
                end else begin
                    trap_now = 1'b1;
                end
            end
            ST_SEARCH: if (step_en) begin
                if (!valid_a) begin
                    trap_now = 1'b1;
                end else if (a_pre_w && word_a.len == suffix.len) begin
                    found_now = 1'b1;
                end else if (a_pre_w) begin
                    advance  = 1'b1;
                    adv_word = drop_prefix(suffix, word_a.len);
                end else if (w_pre_a && suffix.len < word_a.len) begin
                    advance  = 1'b1;
                    adv_word = drop_prefix(word_a, suffix.len);
                end else begin
                    trap_now = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // DONE lasts one cycle and falls back to IDLE so the codebook can be reloaded;
    // the verdict flags stay sticky until the next start or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            suffix    <= '0;
            step_cnt  <= '0;
            found     <= 1'b0;
            trap      <= 1'b0;
            exhausted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start && !load_en) begin
                    state     <= ST_START;
                    suffix    <= '0;
                    step_cnt  <= '0;
                    found     <= 1'b0;
                    trap      <= 1'b0;
                    exhausted <= 1'b0;
                end
                ST_START, ST_SEARCH: begin
                    if (trap_now) begin
                        trap  <= 1'b1;
                        state <= ST_DONE;
                    end else if (found_now) begin
                        found <= 1'b1;
                        state <= ST_DONE;
                    end else if (advance) begin
                        suffix   <= adv_word;
                        step_cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            exhausted <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_SEARCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state == ST_START) || (state == ST_SEARCH);
    assign cur_len = suffix.len[LEN_W-1:0];

endmodule

// File: tb/tb_unidec_param_checker.sv
// Directed bench: instance a uses the default 3-bit alphabet, instance b a 1-bit alphabet with MAX_STEPS=4.
module tb_unidec_param_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        load_en_a, start_a, step_en_a;
    logic [2:0]  load_idx_a, load_len_a, sel_word_a, sel_alt_a;
    logic [14:0] load_sym_a;
    logic        busy_a, found_a, trap_a, exhausted_a;
    logic [3:0]  step_cnt_a;
    logic [2:0]  cur_len_a;

    logic        load_en_b, start_b, step_en_b;
    logic [2:0]  load_idx_b, load_len_b, sel_word_b, sel_alt_b;
    logic [4:0]  load_sym_b;
    logic        busy_b, found_b, trap_b, exhausted_b;
    logic [2:0]  step_cnt_b;
    logic [2:0]  cur_len_b;

    unidec_param_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_en(load_en_a), .load_idx(load_idx_a), .load_sym(load_sym_a),
        .load_len(load_len_a), .start(start_a), .step_en(step_en_a), .sel_word(sel_word_a),
        .sel_alt(sel_alt_a), .busy(busy_a), .found(found_a), .trap(trap_a), .exhausted(exhausted_a),
        .step_cnt(step_cnt_a), .cur_len(cur_len_a)
    );

    unidec_param_checker #(.SYM_W(1), .MAX_STEPS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_en(load_en_b), .load_idx(load_idx_b), .load_sym(load_sym_b),
        .load_len(load_len_b), .start(start_b), .step_en(step_en_b), .sel_word(sel_word_b),
        .sel_alt(sel_alt_b), .busy(busy_b), .found(found_b), .trap(trap_b), .exhausted(exhausted_b),
        .step_cnt(step_cnt_b), .cur_len(cur_len_b)
    );

    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [7:0] exp_q[$];
    int         chain_sel[4] = '{6, 1, 5, 4};
    int         pf_word[4]   = '{0, 1, 2, 0};
    int         pf_alt[4]    = '{1, 2, 2, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] w3(input int s0, input int s1, input int s2, input int s3, input int s4);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic load_a(input int idx, input logic [14:0] sym, input int len);
        load_en_a = 1'b1; load_idx_a = 3'(idx); load_sym_a = sym; load_len_a = 3'(len);
        tick();
        load_en_a = 1'b0;
    endtask

    task automatic start_run_a();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic step_a(input int w, input int alt);
        step_en_a = 1'b1; sel_word_a = 3'(w); sel_alt_a = 3'(alt);
        tick();
        step_en_a = 1'b0;
    endtask

    task automatic load_b(input int idx, input logic [4:0] sym, input int len);
        load_en_b = 1'b1; load_idx_b = 3'(idx); load_sym_b = sym; load_len_b = 3'(len);
        tick();
        load_en_b = 1'b0;
    endtask

    task automatic start_run_b();
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic step_b(input int w, input int alt);
        step_en_b = 1'b1; sel_word_b = 3'(w); sel_alt_b = 3'(alt);
        tick();
        step_en_b = 1'b0;
    endtask

    initial begin
        #200000;
        err_cnt++;
        chk_cnt++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        load_en_a = 0; start_a = 0; step_en_a = 0; load_idx_a = 0; load_len_a = 0; load_sym_a = 0;
        sel_word_a = 0; sel_alt_a = 0;
        load_en_b = 0; start_b = 0; step_en_b = 0; load_idx_b = 0; load_len_b = 0; load_sym_b = 0;
        sel_word_b = 0; sel_alt_b = 0;
        tick();
        tick();
        check("rst_busy", busy_a, 0);
        check("rst_found", found_a, 0);
        check("rst_trap", trap_a, 0);
        check("rst_exhausted", exhausted_a, 0);
        check("rst_step_cnt", step_cnt_a, 0);
        check("rst_cur_len", cur_len_a, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // code {a,c,ad,abb,bad,deb,bbcde}, a=0 .. e=4
        load_a(0, w3(0, 0, 0, 0, 0), 1);
        load_a(1, w3(2, 0, 0, 0, 0), 1);
        load_a(2, w3(0, 3, 0, 0, 0), 2);
        load_a(3, w3(0, 1, 1, 0, 0), 3);
        load_a(4, w3(1, 0, 3, 0, 0), 3);
        load_a(5, w3(3, 4, 1, 0, 0), 3);
        load_a(6, w3(1, 1, 2, 3, 4), 5);

        start_run_a();
        check("start_busy", busy_a, 1);
        step_a(0, 3);
        check("first_len", cur_len_a, 2);
        check("first_cnt", step_cnt_a, 1);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        for (int i = 0; i < 4; i++) begin
            step_a(chain_sel[i], 0);
            check("chain_len", cur_len_a, exp_q.pop_front());
            check("chain_cnt", step_cnt_a, i + 2);
            check("chain_busy", busy_a, 1);
        end
        step_a(2, 0);
        check("found_flag", found_a, 1);
        check("found_cnt", step_cnt_a, 5);
        check("found_busy", busy_a, 0);
        check("found_trap", trap_a, 0);
        check("found_exh", exhausted_a, 0);

        start_run_a();
        check("restart_found_clr", found_a, 0);
        check("restart_cnt_clr", step_cnt_a, 0);
        step_a(0, 2);
        check("d_len", cur_len_a, 1);
        step_a(0, 0);
        check("d_trap", trap_a, 1);
        check("d_found", found_a, 0);
        check("d_busy", busy_a, 0);
        check("d_cnt", step_cnt_a, 1);

        start_run_a();
        step_a(0, 3);
        repeat (3) tick();
        check("hold_len", cur_len_a, 2);
        check("hold_cnt", step_cnt_a, 1);
        check("hold_busy", busy_a, 1);

        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_a, 0);
        check("midrst_len", cur_len_a, 0);
        check("midrst_cnt", step_cnt_a, 0);
        check("midrst_found", found_a, 0);
        check("midrst_trap", trap_a, 0);
        @(negedge clk) rst_n = 1'b1;
        start_run_a();
        step_a(0, 3);
        check("empty_trap", trap_a, 1);
        check("empty_busy", busy_a, 0);

        tick();
        load_en_a = 1'b1; start_a = 1'b1; load_idx_a = 3'd0; load_sym_a = w3(0, 0, 0, 0, 0); load_len_a = 3'd1;
        tick();
        load_en_a = 1'b0; start_a = 1'b0;
        check("ls_busy", busy_a, 0);
        tick();
        check("ls_idle", busy_a, 0);
        load_a(1, w3(0, 1, 0, 0, 0), 2);
        start_run_a();
        step_a(0, 1);
        check("ls_len", cur_len_a, 1);
        check("ls_cnt", step_cnt_a, 1);

        // prefix-free code {0,10,11} over a 1-bit alphabet
        load_b(0, 5'b00000, 1);
        load_b(1, 5'b00001, 2);
        load_b(2, 5'b00011, 2);
        for (int i = 0; i < 4; i++) begin
            start_run_b();
            step_b(pf_word[i], pf_alt[i]);
            check("pf_trap", trap_b, 1);
            check("pf_found", found_b, 0);
        end

        // {a,ab,bb}: suffix b repeats until the step budget runs out
        tick();
        load_b(0, 5'b00000, 1);
        load_b(1, 5'b00010, 2);
        load_b(2, 5'b00011, 2);
        start_run_b();
        step_b(0, 1);
        check("ex_first_len", cur_len_b, 1);
        check("ex_first_cnt", step_cnt_b, 1);
        for (int i = 0; i < 2; i++) begin
            step_b(2, 0);
            check("ex_cnt", step_cnt_b, i + 2);
            check("ex_len", cur_len_b, 1);
            check("ex_not_yet", exhausted_b, 0);
        end
        step_b(2, 0);
        check("ex_flag", exhausted_b, 1);
        check("ex_final_cnt", step_cnt_b, 4);
        check("ex_busy", busy_b, 0);
        check("ex_found", found_b, 0);
        check("ex_trap", trap_b, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
